// File: rtl/iq_modulator_nco.sv
// Digital IQ upconverter: sample-coherent NCO, quarter-shifted sine LUT, three-stage mixer pipeline.
module iq_modulator_nco #(
    parameter int unsigned DW      = 16,
    parameter int unsigned CW      = 16,
    parameter int unsigned PW      = 28,
    parameter int unsigned LAW     = 10,
    parameter int unsigned FCW_RST = 13421772,
    parameter int unsigned OW      = DW + CW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fcw_wr,
    input  logic [PW-1:0]        fcw_in,
    input  logic                 ph_clr,
    input  logic [1:0]           mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] i_in,
    input  logic signed [DW-1:0] q_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_data
);

    localparam int unsigned LN  = 2 ** LAW;
    localparam int unsigned QTR = 2 ** (LAW - 2);
    localparam int unsigned MW  = DW + CW;

    // Rounded full-cycle sine sample k, evaluated at elaboration only
    function automatic logic signed [CW-1:0] lut_val(input int unsigned k);
        real amp;
        real ang;
        real v;
        amp = (2.0 ** (CW - 1)) - 1.0;
        ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(LN);
        v   = amp * $sin(ang);
        v   = (v >= 0.0) ? v + 0.5 : v - 0.5;
        return CW'($rtoi(v));
    endfunction

    logic signed [CW-1:0] lut [LN];

    // Constant sine table
    for (genvar k = 0; k < LN; k++) begin : g_lut
        localparam logic signed [CW-1:0] LV = lut_val(k);
        assign lut[k] = LV;
    end

    logic [PW-1:0]        acc_q, acc_d, fcw_q, fcw_d;
    logic                 v1_q, v1_d, v2_q, v2_d, out_valid_q, out_valid_d;
    logic signed [CW-1:0] sin1_q, sin1_d, cos1_q, cos1_d, cos2_q, cos2_d;
    logic signed [DW-1:0] i1_q, i1_d, q1_q, q1_d, i2_q, i2_d;
    logic [1:0]           mode1_q, mode1_d, mode2_q, mode2_d;
    logic signed [MW-1:0] pi2_q, pi2_d, pq2_q, pq2_d;
    logic signed [OW-1:0] out_data_q, out_data_d;

    logic                 en;
    logic                 accept;
    logic [LAW-1:0]       idx;
    logic [LAW-1:0]       cidx;

    assign en        = !out_valid_q || out_ready;
    assign accept    = in_valid && en;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign idx       = acc_q[PW-1 -: LAW];
    assign cidx      = idx + LAW'(QTR);

    // Next-state for NCO, LUT stage, multiplier stage and output stage
    always_comb begin
        acc_d       = acc_q;
        fcw_d       = fcw_q;
        v1_d        = v1_q;
        sin1_d      = sin1_q;
        cos1_d      = cos1_q;
        i1_d        = i1_q;
        q1_d        = q1_q;
        mode1_d     = mode1_q;
        v2_d        = v2_q;
        pi2_d       = pi2_q;
        pq2_d       = pq2_q;
        cos2_d      = cos2_q;
        i2_d        = i2_q;
        mode2_d     = mode2_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (fcw_wr) begin
            fcw_d = fcw_in;
        end
        if (ph_clr) begin
            acc_d = '0;
        end else if (accept) begin
            acc_d = acc_q + fcw_q;
        end

        if (en) begin
            v1_d    = accept;
            sin1_d  = lut[idx];
            cos1_d  = lut[cidx];
            i1_d    = i_in;
            q1_d    = q_in;
            mode1_d = mode;

            v2_d    = v1_q;
            pi2_d   = MW'(i1_q) * MW'(cos1_q);
            pq2_d   = MW'(q1_q) * MW'(sin1_q);
            cos2_d  = cos1_q;
            i2_d    = i1_q;
            mode2_d = mode1_q;

            out_valid_d = v2_q;
            if (v2_q) begin
                case (mode2_q)
                    2'b00:   out_data_d = OW'(pi2_q) + OW'(pq2_q);
                    2'b01:   out_data_d = OW'(pi2_q) - OW'(pq2_q);
                    2'b10:   out_data_d = OW'(cos2_q);
                    default: out_data_d = OW'(i2_q);
                endcase
            end
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            fcw_q       <= PW'(FCW_RST);
            v1_q        <= 1'b0;
            sin1_q      <= '0;
            cos1_q      <= '0;
            i1_q        <= '0;
            q1_q        <= '0;
            mode1_q     <= '0;
            v2_q        <= 1'b0;
            pi2_q       <= '0;
            pq2_q       <= '0;
            cos2_q      <= '0;
            i2_q        <= '0;
            mode2_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            acc_q       <= acc_d;
            fcw_q       <= fcw_d;
            v1_q        <= v1_d;
            sin1_q      <= sin1_d;
            cos1_q      <= cos1_d;
            i1_q        <= i1_d;
            q1_q        <= q1_d;
            mode1_q     <= mode1_d;
            v2_q        <= v2_d;
            pi2_q       <= pi2_d;
            pq2_q       <= pq2_d;
            cos2_q      <= cos2_d;
            i2_q        <= i2_d;
            mode2_q     <= mode2_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_iq_modulator_nco.sv
// Directed bench for iq_modulator_nco with a queue of hand-computed expected outputs.
module tb_iq_modulator_nco;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;
    localparam int unsigned PW = 28;
    localparam int unsigned OW = DW + CW + 1;
    localparam int unsigned F_Q = 32'd67108864;   // quarter turn per sample
    localparam int unsigned F_H = 32'd134217728;  // half turn per sample

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 fcw_wr = 1'b0;
    logic [PW-1:0]        fcw_in = '0;
    logic                 ph_clr = 1'b0;
    logic [1:0]           mode = 2'b00;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] i_in = '0;
    logic signed [DW-1:0] q_in = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [OW-1:0] out_data;

    typedef struct {
        longint exp;
        bit     lat;
        int     acyc;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nout  = 0;
    bit stall_prev = 1'b0;
    logic signed [OW-1:0] held;

    iq_modulator_nco dut (
        .clk       (clk),
        .rst       (rst),
        .fcw_wr    (fcw_wr),
        .fcw_in    (fcw_in),
        .ph_clr    (ph_clr),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .i_in      (i_in),
        .q_in      (q_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One accepted sample; expectation queued on the accepting cycle
    task automatic send(input int iv, input int qv, input int m, input longint e,
                        input bit lat, input bit fw, input int unsigned fv,
                        input bit pc, input bit push);
        bit done;
        done     = 1'b0;
        i_in     = 16'(iv);
        q_in     = 16'(qv);
        mode     = 2'(m);
        in_valid = 1'b1;
        fcw_wr   = fw;
        fcw_in   = 28'(fv);
        ph_clr   = pc;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
                if (push) q.push_back(exp_t'{e, lat, cyc + 1});
            end
            @(posedge clk);
            #1;
        end
        if (!done) check_eq("send_timeout", 0, 1);
        in_valid = 1'b0;
        fcw_wr   = 1'b0;
        ph_clr   = 1'b0;
    endtask

    task automatic s(input int iv, input int qv, input int m, input longint e);
        send(iv, qv, m, e, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic idle(input bit fw, input int unsigned fv, input bit pc);
        fcw_wr = fw;
        fcw_in = 28'(fv);
        ph_clr = pc;
        @(posedge clk);
        #1;
        fcw_wr = 1'b0;
        ph_clr = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 50 && q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        check_eq(tag, q.size(), 0);
    endtask

    // Output monitor: scoreboard compare and backpressure hold checks
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (out_valid && !out_ready) begin
                check_eq("bp_in_ready", in_ready, 0);
                if (stall_prev) check_eq("bp_hold", out_data, held);
                held       = out_data;
                stall_prev = 1'b1;
            end else begin
                stall_prev = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check_eq("spurious_valid", out_valid, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check_eq($sformatf("out%0d", nout), out_data, e.exp);
                    if (e.lat) check_eq("latency", cyc - e.acyc + 1, 3);
                end
                nout++;
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        rst = 1'b0;
        #1;
        check_eq("rst_in_ready", in_ready, 1);

        idle(1'b1, F_Q, 1'b0);

        // Scenario 1: cosine carrier on I
        send(1000, 0, 0, 32767000, 1'b1, 1'b0, 0, 1'b0, 1'b1);
        s(1000, 0, 0, 0);
        s(1000, 0, 0, -32767000);
        s(1000, 0, 0, 0);

        // Scenario 2: mode 01 then 00 on Q
        s(0, 1000, 1, 0);
        s(0, 1000, 1, -32767000);
        s(0, 1000, 1, 0);
        s(0, 1000, 1, 32767000);
        s(0, 1000, 0, 0);
        s(0, 1000, 0, 32767000);
        s(0, 1000, 0, 0);
        s(0, 1000, 0, -32767000);
        drain("drain_s2");

        // Scenario 3: backpressure mid-stream
        fork
            begin
                for (int r = 0; r < 2; r++) begin
                    s(-700, 300, 0, -22936900);
                    s(-700, 300, 0, 9830100);
                    s(-700, 300, 0, 22936900);
                    s(-700, 300, 0, -9830100);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("drain_s3");

        // Scenario 4: carrier only, FCW change and phase clears
        s(0, 0, 2, 32767);
        s(0, 0, 2, 0);
        s(0, 0, 2, -32767);
        send(0, 0, 2, 0, 1'b0, 1'b1, F_H, 1'b0, 1'b1);
        s(0, 0, 2, 32767);
        s(0, 0, 2, -32767);
        s(0, 0, 2, 32767);
        send(0, 0, 2, -32767, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        s(0, 0, 2, 32767);
        send(0, 0, 2, -32767, 1'b0, 1'b1, F_Q, 1'b1, 1'b1);
        s(0, 0, 2, 32767);
        s(0, 0, 2, 0);
        s(-5, 77, 3, -5);
        s(-1000, -2, 1, -65534);

        // Scenario 5: sparse input, phase advances per sample
        idle(1'b0, 0, 1'b1);
        s(1000, 0, 0, 32767000);
        idle(1'b0, 0, 1'b0);
        idle(1'b0, 0, 1'b0);
        s(1000, 0, 0, 0);
        idle(1'b0, 0, 1'b0);
        idle(1'b0, 0, 1'b0);
        s(1000, 0, 0, -32767000);
        idle(1'b0, 0, 1'b0);
        idle(1'b0, 0, 1'b0);
        s(1000, 0, 0, 0);
        drain("drain_s5");

        // Scenario 6: reset with samples in flight
        send(1000, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        send(1000, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        send(1000, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        check_eq("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check_eq("async_rst_valid", out_valid, 0);
        check_eq("async_rst_data", out_data, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("post_rst_no_output", out_valid, 0);
        s(0, 0, 2, 32767);
        s(0, 0, 2, 31176);
        drain("drain_s6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
